odo_sbox_small_seq: RTL and testbench

- Time-multiplexed sequencer that applies one shared 6-bit small S-box instance to a packed vector of LANES 6-bit lanes.
- Upstream: accepts a whole vector over a valid/ready handshake, then presents one lane per cycle on sbox_in.
- Downstream: collects the registered S-box result one cycle later and re-packs the results into an output vector with valid/ready.
- Sits between the round-state datapath and a single odo_sbox_small* instance, trading throughput for area.

---
 rtl/odo_sbox_small_seq.sv | 98 +++++++++
 tb/tb_odo_sbox_small_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/odo_sbox_small_seq.sv
// rtl/odo_sbox_small_seq.sv - time-multiplexes one registered 6-bit S-box across LANES packed lanes
module odo_sbox_small_seq #(
    parameter int LANES = 8,
    parameter int CW    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6*LANES-1:0] in_data,
    output logic [5:0]         sbox_in,
    input  logic [5:0]         sbox_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6*LANES-1:0] out_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    state_t             state;
    logic [6*LANES-1:0] lane_sr;
    logic [6*LANES-1:0] result_sr;
    logic [CW-1:0]      issue_cnt;
    logic [CW-1:0]      collect_cnt;
    logic               capture;

    // The S-box sees a plain register slice, so nothing upstream leaks into its timing path.
    assign sbox_in  = lane_sr[5:0];
    assign out_data = result_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lane_sr     <= '0;
            result_sr   <= '0;
            issue_cnt   <= '0;
            collect_cnt <= '0;
            capture     <= 1'b0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            // capture trails issuing by one cycle to match the S-box register stage
            capture <= 1'b0;
            if (capture) begin
                result_sr   <= {sbox_out, result_sr[6*LANES-1:6]};
                collect_cnt <= collect_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        lane_sr     <= in_data;
                        issue_cnt   <= '0;
                        collect_cnt <= '0;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    lane_sr   <= {6'd0, lane_sr[6*LANES-1:6]};
                    issue_cnt <= issue_cnt + 1'b1;
                    capture   <= 1'b1;
                    if (issue_cnt == LAST) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (capture && collect_cnt == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odo_sbox_small_seq.sv
// tb/tb_odo_sbox_small_seq.sv - directed self-checking bench for odo_sbox_small_seq
module tb_odo_sbox_small_seq;

    localparam int LANES = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [6*LANES-1:0] in_data;
    logic [5:0]        sbox_in;
    logic [5:0]        sbox_q;
    logic              out_valid;
    logic              out_ready;
    logic [6*LANES-1:0] out_data;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [6*LANES-1:0] last_out = '0;

    odo_sbox_small_seq #(.LANES(LANES), .CW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Known entries of the attached small S-box; other inputs map to an arbitrary distinct value.
    function automatic logic [5:0] sbox_ref(input logic [5:0] x);
        case (x)
            6'h00:   sbox_ref = 6'h0D;
            6'h01:   sbox_ref = 6'h08;
            6'h02:   sbox_ref = 6'h2B;
            6'h03:   sbox_ref = 6'h1A;
            6'h3F:   sbox_ref = 6'h1E;
            6'h20:   sbox_ref = 6'h2D;
            6'h0A:   sbox_ref = 6'h00;
            6'h15:   sbox_ref = 6'h3F;
            default: sbox_ref = x ^ 6'h2A;
        endcase
    endfunction

    always @(posedge clk) begin
        sbox_q <= sbox_ref(sbox_in);
        cyc    <= cyc + 1;
        if (out_valid && out_ready) last_out <= out_data;
    end

    function automatic logic [47:0] splat(input logic [5:0] x);
        splat = {8{x}};
    endfunction

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [47:0] v, output int acc);
        int n;
        in_data  = v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("send_ready", {47'd0, in_ready}, 48'd1);
        tick();
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("wait_out_valid", {47'd0, out_valid}, 48'd1);
    endtask

    logic [47:0] v1, r1, va, ra;
    logic [5:0]  lanes1 [8];
    int          a0, a1, a2;
    logic        seen;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        lanes1 = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h3F, 6'h20, 6'h0A, 6'h15};
        v1 = {6'h15, 6'h0A, 6'h20, 6'h3F, 6'h03, 6'h02, 6'h01, 6'h00};
        r1 = {6'h3F, 6'h00, 6'h2D, 6'h1E, 6'h1A, 6'h2B, 6'h08, 6'h0D};
        va = {6'h00, 6'h01, 6'h02, 6'h03, 6'h3F, 6'h20, 6'h0A, 6'h15};
        ra = {6'h0D, 6'h08, 6'h2B, 6'h1A, 6'h1E, 6'h2D, 6'h00, 6'h3F};

        // reset held with in_valid high
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = splat(6'h15);
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", {47'd0, out_valid}, 48'd0);
        chk("rst_out_data", out_data, 48'd0);
        chk("rst_sbox_in", {42'd0, sbox_in}, 48'd0);
        chk("rst_busy", {47'd0, busy}, 48'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        chk("rst_in_ready", {47'd0, in_ready}, 48'd1);

        // single vector: lane order, latency, result
        send(v1, a0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sbox_in_%0d", i), {42'd0, sbox_in}, {42'd0, lanes1[i]});
            chk($sformatf("busy_%0d", i), {47'd0, busy}, 48'd1);
            tick();
        end
        chk("early_out_valid", {47'd0, out_valid}, 48'd0);
        wait_out();
        chk("latency", 48'(cyc - a0), 48'd9);
        chk("single_data", out_data, r1);

        // backpressure in DONE
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_data_%0d", i), out_data, r1);
            chk($sformatf("bp_in_ready_%0d", i), {47'd0, in_ready}, 48'd0);
            chk($sformatf("bp_valid_%0d", i), {47'd0, out_valid}, 48'd1);
            chk($sformatf("bp_sbox_in_%0d", i), {42'd0, sbox_in}, 48'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", {47'd0, out_valid}, 48'd0);
        chk("bp_release_ready", {47'd0, in_ready}, 48'd1);

        // back-to-back with out_ready high
        out_ready = 1'b1;
        send(va, a1);
        send(splat(6'h3F), a2);
        chk("b2b_gap", 48'(a2 - a1), 48'd11);
        chk("b2b_first_data", last_out, ra);
        wait_out();
        chk("b2b_second_data", out_data, splat(6'h1E));
        tick();
        out_ready = 1'b0;

        // reset in the middle of ISSUE
        send(v1, a0);
        repeat (3) tick();
        chk("abort_lane3", {42'd0, sbox_in}, 48'h03);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", {47'd0, seen}, 48'd0);
        chk("abort_in_ready", {47'd0, in_ready}, 48'd1);
        chk("abort_busy", {47'd0, busy}, 48'd0);
        send(splat(6'h0A), a0);
        wait_out();
        chk("abort_next_latency", 48'(cyc - a0), 48'd9);
        chk("abort_next_data", out_data, splat(6'h00));
        tick();
        out_ready = 1'b0;

        // in_valid pulses during ISSUE are ignored
        send(splat(6'h02), a0);
        for (int i = 0; i < 8; i++) begin
            in_data  = splat(6'h15);
            in_valid = (i % 2 == 0);
            chk($sformatf("ign_in_ready_%0d", i), {47'd0, in_ready}, 48'd0);
            tick();
        end
        in_valid = 1'b0;
        wait_out();
        chk("ign_data", out_data, splat(6'h2B));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ign_idle", {47'd0, in_ready}, 48'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
